// File: rtl/ram_arbiter_if.sv
// Bundle of requester-side and RAM-side signals around the two-master RAM
// arbiter. The arbiter takes the slave view; the environment (masters plus
// RAM controller) takes the master view.
interface ram_arbiter_if;
  // requester 0
  logic [31:0] req0Address;
  logic [31:0] req0WriteData;
  logic        req0ReadReq;
  logic        req0WriteReq;
  logic [31:0] req0ReadData;
  logic        req0ReadAck;
  logic        req0WriteAck;
  // requester 1
  logic [31:0] req1Address;
  logic [31:0] req1WriteData;
  logic        req1ReadReq;
  logic        req1WriteReq;
  logic [31:0] req1ReadData;
  logic        req1ReadAck;
  logic        req1WriteAck;
  // RAM side
  logic [31:0] ramAddress;
  logic [31:0] ramOut;
  logic        readReq;
  logic        writeReq;
  logic [31:0] ramValue;
  logic        readAck;
  logic        writeAck;
  // status
  logic        busy;
  logic        grant;
  logic        timeoutErr;
  logic [1:0]  state_dbg;

  modport slave (
    input  req0Address, req0WriteData, req0ReadReq, req0WriteReq,
    input  req1Address, req1WriteData, req1ReadReq, req1WriteReq,
    input  ramValue, readAck, writeAck,
    output req0ReadData, req0ReadAck, req0WriteAck,
    output req1ReadData, req1ReadAck, req1WriteAck,
    output ramAddress, ramOut, readReq, writeReq,
    output busy, grant, timeoutErr, state_dbg
  );

  modport master (
    output req0Address, req0WriteData, req0ReadReq, req0WriteReq,
    output req1Address, req1WriteData, req1ReadReq, req1WriteReq,
    output ramValue, readAck, writeAck,
    input  req0ReadData, req0ReadAck, req0WriteAck,
    input  req1ReadData, req1ReadAck, req1WriteAck,
    input  ramAddress, ramOut, readReq, writeReq,
    input  busy, grant, timeoutErr, state_dbg
  );
endinterface

// File: rtl/ram_arbiter.sv
// Round-robin arbiter sharing one word-wide RAM port between two masters.
// Handshake: requesters hold ReadReq/WriteReq (level) until they see a
// one-cycle Ack and must drop the request on that same edge; towards the
// RAM the arbiter emits a one-cycle readReq/writeReq pulse and waits for a
// one-cycle readAck/writeAck. Only one transaction is ever outstanding, and
// a watchdog forces completion if the RAM never answers.
module ram_arbiter #(
  parameter int TIMEOUT = 255,
  parameter int TOBITS  = 8
) (
  input  logic         clk,
  input  logic         reset,
  ram_arbiter_if.slave bus
);

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_DONE} state_t;

  state_t              state_q, state_d;
  logic                grant_q, grant_d;
  logic                last_grant_q, last_grant_d;
  logic                op_write_q, op_write_d;
  logic [31:0]         ram_address_q, ram_address_d;
  logic [31:0]         ram_out_q, ram_out_d;
  logic                read_req_q, read_req_d;
  logic                write_req_q, write_req_d;
  logic [31:0]         rd_data0_q, rd_data0_d;
  logic [31:0]         rd_data1_q, rd_data1_d;
  logic                rd_ack0_q, rd_ack0_d;
  logic                rd_ack1_q, rd_ack1_d;
  logic                wr_ack0_q, wr_ack0_d;
  logic                wr_ack1_q, wr_ack1_d;
  logic                timeout_err_q, timeout_err_d;
  logic [TOBITS-1:0]   cnt_q, cnt_d;

  logic                pend0, pend1, sel, sel_write, finish;
  logic [31:0]         fin_data;

  // Next-state and registered-output computation for the whole FSM.
  always_comb begin
    state_d       = state_q;
    grant_d       = grant_q;
    last_grant_d  = last_grant_q;
    op_write_d    = op_write_q;
    ram_address_d = ram_address_q;
    ram_out_d     = ram_out_q;
    read_req_d    = 1'b0;
    write_req_d   = 1'b0;
    rd_data0_d    = rd_data0_q;
    rd_data1_d    = rd_data1_q;
    rd_ack0_d     = 1'b0;
    rd_ack1_d     = 1'b0;
    wr_ack0_d     = 1'b0;
    wr_ack1_d     = 1'b0;
    timeout_err_d = timeout_err_q;
    cnt_d         = cnt_q;
    pend0         = bus.req0ReadReq | bus.req0WriteReq;
    pend1         = bus.req1ReadReq | bus.req1WriteReq;
    sel           = 1'b0;
    sel_write     = 1'b0;
    finish        = 1'b0;
    fin_data      = bus.ramValue;

    case (state_q)
      S_IDLE: begin
        if (pend0 || pend1) begin
          // Tie goes to whoever was not served last.
          sel       = (pend0 && pend1) ? ~last_grant_q : pend1;
          // Write wins when a requester raises both request lines.
          sel_write = sel ? bus.req1WriteReq : bus.req0WriteReq;
          grant_d       = sel;
          op_write_d    = sel_write;
          ram_address_d = sel ? bus.req1Address   : bus.req0Address;
          ram_out_d     = sel ? bus.req1WriteData : bus.req0WriteData;
          read_req_d    = ~sel_write;
          write_req_d   = sel_write;
          state_d       = S_ISSUE;
        end
      end
      S_ISSUE: begin
        cnt_d   = '0;
        state_d = S_WAIT;
      end
      S_WAIT: begin
        if (op_write_q ? bus.writeAck : bus.readAck) begin
          finish = 1'b1;
        end else if (cnt_q == TOBITS'(TIMEOUT - 1)) begin
          finish        = 1'b1;
          timeout_err_d = 1'b1;
          fin_data      = 32'hFFFF_FFFF;
        end else begin
          cnt_d = cnt_q + TOBITS'(1);
        end
        if (finish) begin
          state_d = S_DONE;
          if (op_write_q) begin
            wr_ack0_d = ~grant_q;
            wr_ack1_d = grant_q;
          end else begin
            rd_ack0_d = ~grant_q;
            rd_ack1_d = grant_q;
            if (grant_q) rd_data1_d = fin_data;
            else         rd_data0_d = fin_data;
          end
        end
      end
      S_DONE: begin
        last_grant_d = grant_q;
        state_d      = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State and output registers; reset drops any transaction immediately.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q       <= S_IDLE;
      grant_q       <= 1'b0;
      last_grant_q  <= 1'b1;
      op_write_q    <= 1'b0;
      ram_address_q <= '0;
      ram_out_q     <= '0;
      read_req_q    <= 1'b0;
      write_req_q   <= 1'b0;
      rd_data0_q    <= '0;
      rd_data1_q    <= '0;
      rd_ack0_q     <= 1'b0;
      rd_ack1_q     <= 1'b0;
      wr_ack0_q     <= 1'b0;
      wr_ack1_q     <= 1'b0;
      timeout_err_q <= 1'b0;
      cnt_q         <= '0;
    end else begin
      state_q       <= state_d;
      grant_q       <= grant_d;
      last_grant_q  <= last_grant_d;
      op_write_q    <= op_write_d;
      ram_address_q <= ram_address_d;
      ram_out_q     <= ram_out_d;
      read_req_q    <= read_req_d;
      write_req_q   <= write_req_d;
      rd_data0_q    <= rd_data0_d;
      rd_data1_q    <= rd_data1_d;
      rd_ack0_q     <= rd_ack0_d;
      rd_ack1_q     <= rd_ack1_d;
      wr_ack0_q     <= wr_ack0_d;
      wr_ack1_q     <= wr_ack1_d;
      timeout_err_q <= timeout_err_d;
      cnt_q         <= cnt_d;
    end
  end

  assign bus.req0ReadData = rd_data0_q;
  assign bus.req0ReadAck  = rd_ack0_q;
  assign bus.req0WriteAck = wr_ack0_q;
  assign bus.req1ReadData = rd_data1_q;
  assign bus.req1ReadAck  = rd_ack1_q;
  assign bus.req1WriteAck = wr_ack1_q;
  assign bus.ramAddress   = ram_address_q;
  assign bus.ramOut       = ram_out_q;
  assign bus.readReq      = read_req_q;
  assign bus.writeReq     = write_req_q;
  assign bus.busy         = (state_q != S_IDLE);
  assign bus.grant        = grant_q;
  assign bus.timeoutErr   = timeout_err_q;
  assign bus.state_dbg    = state_q;

endmodule

// File: tb/tb_ram_arbiter.sv
// Directed bench for ram_arbiter: two requester drivers, a byte-addressed
// RAM model answering two cycles after a request pulse, and a scoreboard
// that matches every requester Ack against an expected queue.
module tb_ram_arbiter;
  localparam int W = 34; // {requester id, is_write, read data}

  logic clk = 1'b0;
  logic reset = 1'b1;
  int   cyc = 0;
  int   n_tests = 0;
  int   n_fail = 0;

  ram_arbiter_if bus ();

  ram_arbiter #(.TIMEOUT(4), .TOBITS(8)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  // ---------------- clock / cycle counter ----------------
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #500000;
    $display("FAIL global_timeout: simulation did not finish, cycle %0d", cyc);
    $fatal(1);
  end

  // ---------------- RAM model ----------------
  logic [7:0]  mem [256];
  logic        ram_mute = 1'b0;
  logic        rd_pend = 1'b0;
  logic        wr_pend = 1'b0;
  logic        ram_read_ack = 1'b0;
  logic        ram_write_ack = 1'b0;
  logic [31:0] ram_value = '0;
  logic [31:0] last_ram_out = '0;

  assign bus.readAck  = ram_read_ack;
  assign bus.writeAck = ram_write_ack;
  assign bus.ramValue = ram_value;

  function automatic logic [31:0] mem_word(logic [7:0] a);
    return {mem[8'(a + 8'd3)], mem[8'(a + 8'd2)], mem[8'(a + 8'd1)], mem[a]};
  endfunction

  always @(posedge clk) begin
    logic [7:0] a;
    a = bus.ramAddress[7:0];
    rd_pend       <= bus.readReq & ~ram_mute;
    wr_pend       <= bus.writeReq & ~ram_mute;
    ram_read_ack  <= rd_pend;
    ram_write_ack <= wr_pend;
    if (rd_pend) ram_value <= mem_word(a);
    if (bus.writeReq && !ram_mute) begin
      mem[a]              = bus.ramOut[7:0];
      mem[8'(a + 8'd1)]   = bus.ramOut[15:8];
      mem[8'(a + 8'd2)]   = bus.ramOut[23:16];
      mem[8'(a + 8'd3)]   = bus.ramOut[31:24];
      last_ram_out       <= bus.ramOut;
    end
  end

  // ---------------- scoreboard ----------------
  logic [W-1:0] exp_q [$];
  int           ack_cyc [$];
  logic         req_prev = 1'b0;

  task automatic check(string name, logic [31:0] act, logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // Monitor: request pulse width and every requester Ack against exp_q.
  always @(negedge clk) begin
    logic         req_now;
    int           nacks;
    logic [W-1:0] obs, e;
    req_now = bus.readReq | bus.writeReq;
    if (req_now) begin
      n_tests++;
      if (req_prev) begin
        n_fail++;
        $display("FAIL ram_req_pulse: request high 2 cycles at cycle %0d, expected 1", cyc);
      end
    end
    req_prev = req_now;
    nacks = int'(bus.req0ReadAck) + int'(bus.req0WriteAck) +
            int'(bus.req1ReadAck) + int'(bus.req1WriteAck);
    if (nacks != 0) begin
      ack_cyc.push_back(cyc);
      obs = {bus.req1ReadAck | bus.req1WriteAck,
             bus.req0WriteAck | bus.req1WriteAck,
             bus.req0ReadAck ? bus.req0ReadData :
             bus.req1ReadAck ? bus.req1ReadData : 32'h0};
      n_tests++;
      if (nacks != 1) begin
        n_fail++;
        $display("FAIL ack_onehot: %0d acks high at once, expected 1", nacks);
      end else if (exp_q.size() == 0) begin
        n_fail++;
        $display("FAIL unexpected_ack: got %h with empty expected queue", obs);
      end else begin
        e = exp_q.pop_front();
        if (obs !== e) begin
          n_fail++;
          $display("FAIL scoreboard: got id/wr/data %h, expected %h", obs, e);
        end
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic set_req(input logic id, input logic rd, input logic wr,
                         input logic [31:0] addr, input logic [31:0] wdata);
    if (id) begin
      bus.req1Address = addr; bus.req1WriteData = wdata;
      bus.req1ReadReq = rd;   bus.req1WriteReq = wr;
    end else begin
      bus.req0Address = addr; bus.req0WriteData = wdata;
      bus.req0ReadReq = rd;   bus.req0WriteReq = wr;
    end
  endtask

  // Raise a request at a negedge, wait for its Ack, drop it on that edge.
  // exp_lat counts clock edges from the raise to the Ack (-1: don't check).
  task automatic run_txn(input logic id, input logic rd, input logic wr,
                         input logic [31:0] addr, input logic [31:0] wdata,
                         input int exp_lat);
    int   lat;
    logic got;
    lat = 0;
    got = 1'b0;
    set_req(id, rd, wr, addr, wdata);
    for (int i = 0; i < 40 && !got; i++) begin
      @(negedge clk);
      lat++;
      got = id ? (bus.req1ReadAck | bus.req1WriteAck)
               : (bus.req0ReadAck | bus.req0WriteAck);
    end
    set_req(id, 1'b0, 1'b0, addr, wdata);
    check("txn_ack_seen", 32'(got), 32'd1);
    if (exp_lat >= 0) check("txn_latency", 32'(lat), 32'(exp_lat));
    @(negedge clk);
    check("ack_pulse_width",
          32'(id ? (bus.req1ReadAck | bus.req1WriteAck)
                 : (bus.req0ReadAck | bus.req0WriteAck)), 32'd0);
  endtask

  task automatic pulse_reset();
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    int acks_before;
    set_req(1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
    set_req(1'b1, 1'b0, 1'b0, 32'h0, 32'h0);
    for (int i = 0; i < 256; i++) mem[i] = 8'h00;
    {mem[8'h13], mem[8'h12], mem[8'h11], mem[8'h10]} = 32'h1234_5678;
    {mem[8'h33], mem[8'h32], mem[8'h31], mem[8'h30]} = 32'hA1B2_C3D4;
    {mem[8'h43], mem[8'h42], mem[8'h41], mem[8'h40]} = 32'h55AA_33CC;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);

    // Reset state
    check("rst_ramAddress", bus.ramAddress, 32'h0);
    check("rst_ramOut", bus.ramOut, 32'h0);
    check("rst_req", {30'h0, bus.readReq, bus.writeReq}, 32'h0);
    check("rst_busy", 32'(bus.busy), 32'h0);
    check("rst_grant", 32'(bus.grant), 32'h0);
    check("rst_timeoutErr", 32'(bus.timeoutErr), 32'h0);
    check("rst_req0ReadData", bus.req0ReadData, 32'h0);
    check("rst_req1ReadData", bus.req1ReadData, 32'h0);
    check("rst_state", 32'(bus.state_dbg), 32'h0);

    // Single read from requester 0
    exp_q.push_back({1'b0, 1'b0, 32'h1234_5678});
    run_txn(1'b0, 1'b1, 1'b0, 32'h10, 32'h0, 4);
    check("rd_req0ReadData_held", bus.req0ReadData, 32'h1234_5678);
    check("rd_req1ReadData_untouched", bus.req1ReadData, 32'h0);
    check("rd_idle_after", 32'(bus.busy), 32'h0);

    // Write from requester 1
    exp_q.push_back({1'b1, 1'b1, 32'h0});
    run_txn(1'b1, 1'b0, 1'b1, 32'h20, 32'hCAFE_BABE, 4);
    check("wr_ramOut", last_ram_out, 32'hCAFE_BABE);
    check("wr_bytes", {mem[8'h20], mem[8'h21], mem[8'h22], mem[8'h23]}, 32'hBEBA_FECA);
    check("wr_grant", 32'(bus.grant), 32'h1);
    check("wr_req0ReadData_untouched", bus.req0ReadData, 32'h1234_5678);

    // Read back the written word through requester 0
    exp_q.push_back({1'b0, 1'b0, 32'hCAFE_BABE});
    run_txn(1'b0, 1'b1, 1'b0, 32'h20, 32'h0, 4);

    // Contention from reset: both hold reads, expect 0,1,0,1 at 5-cycle spacing
    pulse_reset();
    ack_cyc.delete();
    exp_q.push_back({1'b0, 1'b0, 32'h1234_5678});
    exp_q.push_back({1'b1, 1'b0, 32'hA1B2_C3D4});
    exp_q.push_back({1'b0, 1'b0, 32'hCAFE_BABE});
    exp_q.push_back({1'b1, 1'b0, 32'h55AA_33CC});
    fork
      begin
        run_txn(1'b0, 1'b1, 1'b0, 32'h10, 32'h0, 4);
        run_txn(1'b0, 1'b1, 1'b0, 32'h20, 32'h0, -1);
      end
      begin
        run_txn(1'b1, 1'b1, 1'b0, 32'h30, 32'h0, -1);
        run_txn(1'b1, 1'b1, 1'b0, 32'h40, 32'h0, -1);
      end
    join
    check("cont_ack_count", 32'(ack_cyc.size()), 32'd4);
    if (ack_cyc.size() == 4)
      for (int i = 0; i < 3; i++)
        check("cont_ack_spacing", 32'(ack_cyc[i+1] - ack_cyc[i]), 32'd5);

    // Watchdog: RAM silent, forced completion after 4 WAIT cycles
    ram_mute = 1'b1;
    exp_q.push_back({1'b0, 1'b0, 32'hFFFF_FFFF});
    run_txn(1'b0, 1'b1, 1'b0, 32'h10, 32'h0, 6);
    check("to_timeoutErr", 32'(bus.timeoutErr), 32'h1);
    ram_mute = 1'b0;
    exp_q.push_back({1'b1, 1'b0, 32'hA1B2_C3D4});
    run_txn(1'b1, 1'b1, 1'b0, 32'h30, 32'h0, 4);
    check("to_timeoutErr_sticky", 32'(bus.timeoutErr), 32'h1);
    check("to_req0ReadData", bus.req0ReadData, 32'hFFFF_FFFF);

    // Reset while in WAIT: everything clears, late readAck is dropped
    acks_before = ack_cyc.size();
    set_req(1'b0, 1'b1, 1'b0, 32'h10, 32'h0);
    @(negedge clk);
    check("rw_readReq_pulse", 32'(bus.readReq), 32'h1);
    @(negedge clk);
    check("rw_in_wait", 32'(bus.state_dbg), 32'h2);
    reset = 1'b1;
    set_req(1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
    #1;
    check("rw_busy", 32'(bus.busy), 32'h0);
    check("rw_ramAddress", bus.ramAddress, 32'h0);
    check("rw_timeoutErr", 32'(bus.timeoutErr), 32'h0);
    check("rw_req0ReadData", bus.req0ReadData, 32'h0);
    check("rw_req1ReadData", bus.req1ReadData, 32'h0);
    check("rw_grant", 32'(bus.grant), 32'h0);
    @(negedge clk);
    check("rw_late_readAck_present", 32'(bus.readAck), 32'h1);
    reset = 1'b0;
    repeat (4) @(negedge clk);
    check("rw_no_ack_after_reset", 32'(ack_cyc.size()), 32'(acks_before));
    check("rw_still_idle", 32'(bus.busy), 32'h0);
    exp_q.push_back({1'b1, 1'b0, 32'h55AA_33CC});
    run_txn(1'b1, 1'b1, 1'b0, 32'h40, 32'h0, 4);

    // ReadReq and WriteReq together on requester 0: write wins
    exp_q.push_back({1'b0, 1'b1, 32'h0});
    run_txn(1'b0, 1'b1, 1'b1, 32'h50, 32'h0BAD_F00D, 4);
    check("rwboth_mem", mem_word(8'h50), 32'h0BAD_F00D);
    check("rwboth_req0ReadData", bus.req0ReadData, 32'h0);

    repeat (3) @(negedge clk);
    check("exp_q_drained", 32'(exp_q.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
